// File: rtl/vga_pkg.sv
// Shared definitions for the VGA video-RAM path: default geometry,
// read-tag encoding and the line-fetch state encoding.
package vga_pkg;

  localparam int AW_DEF         = 13;
  localparam int DW_DEF         = 16;
  localparam int H_PIXELS       = 800;
  localparam int LINE_WORDS_DEF = H_PIXELS / DW_DEF;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int LOW_MARK_DEF   = 2;

  // Tag of the RAM read issued last cycle; steers ram_rdata on return.
  typedef enum logic [1:0] {
    TAG_NONE  = 2'd0,
    TAG_VIDEO = 2'd1,
    TAG_CPU   = 2'd2
  } rd_tag_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } fetch_state_e;

  // Pointer width that stays at least one bit for tiny depths.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/vram_fifo.sv
// First-word-fall-through FIFO for scanline prefetch; the head word is
// visible on rdata whenever the FIFO is not empty.
module vram_fifo
  import vga_pkg::*;
#(
  parameter int  DW    = DW_DEF,
  parameter int  DEPTH = FIFO_DEPTH_DEF,
  localparam int PW    = clog2_min1(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam logic [CW-1:0] DEPTH_L = CW'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == DEPTH_L);
  assign count   = count_reg;
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so push is legal even when full.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (do_push && !do_pop)
        count_reg <= count_reg + 1'b1;
      else if (!do_push && do_pop)
        count_reg <= count_reg - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push && !flush)
      mem[wr_ptr_reg] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: keeps the scanline prefetch FIFO topped up
// with deadline priority and hands the remaining slots to the CPU data port.
module vram_arbiter
  import vga_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int LOW_MARK   = LOW_MARK_DEF
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          vid_start,
  input  logic [AW-1:0] vid_base,
  input  logic          vid_pop,
  output logic [DW-1:0] vid_data,
  output logic          vid_empty,
  output logic          vid_underrun,
  input  logic          cpu_valid,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ready,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy
);

  localparam int WLW = $clog2(LINE_WORDS + 1);
  localparam int CW  = clog2_min1(FIFO_DEPTH) + 1;

  localparam logic [WLW-1:0] LINE_L  = WLW'(LINE_WORDS);
  localparam logic [WLW-1:0] WL_ONE  = WLW'(1);
  localparam logic [CW-1:0]  DEPTH_L = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]  LOW_L   = CW'(LOW_MARK);

  fetch_state_e   state_reg, state_next;
  logic [AW-1:0]  fetch_addr_reg, fetch_addr_next;
  logic [WLW-1:0] words_left_reg, words_left_next;
  rd_tag_e        tag_reg, tag_next;
  logic [AW-1:0]  ram_addr_reg;
  logic [DW-1:0]  ram_wdata_reg;
  logic [DW-1:0]  rdata_hold_reg;
  logic           underrun_reg;

  logic           grant_vid;
  logic           grant_cpu;
  logic           vid_eligible;
  logic [CW-1:0]  fifo_count;
  logic           fifo_full;
  logic [CW-1:0]  level;
  logic           fifo_push;

  // Words already queued plus the one video read still in the RAM pipeline.
  assign level = fifo_count + CW'(tag_reg == TAG_VIDEO);

  always_comb begin
    state_next      = state_reg;
    fetch_addr_next = fetch_addr_reg;
    words_left_next = words_left_reg;
    tag_next        = TAG_NONE;
    grant_vid       = 1'b0;
    grant_cpu       = 1'b0;
    ram_addr        = ram_addr_reg;
    ram_we          = 1'b0;
    ram_wdata       = ram_wdata_reg;

    // No video read on a restart cycle: it would return into the new line.
    vid_eligible = (state_reg == ST_FETCH) && !fifo_full
                   && (level < DEPTH_L) && !vid_start;

    if (reset) begin
      if (vid_eligible && ((level < LOW_L) || !cpu_valid))
        grant_vid = 1'b1;
      else if (cpu_valid)
        grant_cpu = 1'b1;
    end

    if (grant_vid) begin
      ram_addr        = fetch_addr_reg;
      fetch_addr_next = fetch_addr_reg + 1'b1;
      words_left_next = words_left_reg - 1'b1;
      tag_next        = TAG_VIDEO;
      if (words_left_reg == WL_ONE)
        state_next = ST_IDLE;
    end else if (grant_cpu) begin
      ram_addr = cpu_addr;
      ram_we   = cpu_we;
      if (cpu_we)
        ram_wdata = cpu_wdata;
      else
        tag_next = TAG_CPU;
    end

    if (vid_start) begin
      fetch_addr_next = vid_base;
      words_left_next = LINE_L;
      state_next      = ST_FETCH;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      fetch_addr_reg <= '0;
      words_left_reg <= '0;
      tag_reg        <= TAG_NONE;
      ram_addr_reg   <= '0;
      ram_wdata_reg  <= '0;
      rdata_hold_reg <= '0;
      underrun_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      fetch_addr_reg <= fetch_addr_next;
      words_left_reg <= words_left_next;
      tag_reg        <= tag_next;
      ram_addr_reg   <= ram_addr;
      ram_wdata_reg  <= ram_wdata;
      if (tag_reg == TAG_CPU)
        rdata_hold_reg <= ram_rdata;
      if (vid_start)
        underrun_reg <= 1'b0;
      else if (vid_pop && vid_empty)
        underrun_reg <= 1'b1;
    end
  end

  // A video word returning on a restart cycle belongs to the old line.
  assign fifo_push = (tag_reg == TAG_VIDEO) && !vid_start;

  vram_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .reset (reset),
    .flush (vid_start),
    .push  (fifo_push),
    .pop   (vid_pop),
    .wdata (ram_rdata),
    .rdata (vid_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (vid_empty)
  );

  assign cpu_ready    = grant_cpu;
  assign cpu_rvalid   = (tag_reg == TAG_CPU);
  assign cpu_rdata    = cpu_rvalid ? ram_rdata : rdata_hold_reg;
  assign vid_underrun = underrun_reg;
  assign busy         = (state_reg == ST_FETCH);

endmodule
